mul_issue_ctrl: RTL and testbench
=================================

// Module: mul_issue_ctrl
// PURPOSE
//  Sequencing stage that wraps the combinational 32x32 signed (Booth) multiplier.
//  - Latches two operands on a start request.
//  - Holds them stable on the multiplier inputs for SETTLE_CYCLES.
//  - Captures the 64-bit product into the ZHI/ZLO register pair.
//  - Returns the product to the datapath as two 32-bit beats, LO first, over a valid/ready handshake.
// PARAMETERS
//  SETTLE_CYCLES  2  clock edges between operand latch and product capture; legal range 1..15
//  CNT_W          4  width of the settle counter; must satisfy 2**CNT_W > SETTLE_CYCLES
// PORTS
//  clock      in   1   rising-edge clock
//  clear      in   1   asynchronous, active-high reset
//  start      in   1   operation request; accepted only when busy=0
//  op_a       in   32  multiplier operand (signed, two's complement)
//  op_b       in   32  multiplicand operand (signed, two's complement)
//  mul_in1    out  32  to multiplier in1; equals latched op_a
//  mul_in2    out  32  to multiplier in2; equals latched op_b
//  mul_zlow   in   32  product bits [31:0] from multiplier
//  mul_zhigh  in   32  product bits [63:32] from multiplier
//  busy       out  1   high in every state except IDLE
//  res_valid  out  1   result beat available
//  res_ready  in   1   consumer accepts the beat when res_valid & res_ready
//  res_data   out  32  ZLO in the LO beat, ZHI in the HI beat, 0 otherwise
//  res_last   out  1   high during the HI beat only
//  zlo_q      out  32  ZLO register contents
//  zhi_q      out  32  ZHI register contents
//  res_sign   out  1   zhi_q[31]
//  res_ovf    out  1   high when zhi_q != {32{zlo_q[31]}} (product does not fit in signed 32 bits)
// BEHAVIOUR
//  - Reset (clear=1, asynchronous):
//    - state=IDLE; operand regs, ZHI, ZLO and counter cleared to 0.
//    - Outputs take their reset values immediately, without waiting for a clock edge:
//      busy=0, res_valid=0, res_last=0, res_data=0, mul_in1=0, mul_in2=0, res_ovf=0.
//  - Reset mid-operation aborts the operation; no further beats are emitted.
//  - States: IDLE -> WAIT -> LO -> HI -> IDLE.
//  - IDLE: start=1 at edge k latches op_a/op_b, loads cnt=SETTLE_CYCLES-1 and goes to WAIT.
//  - WAIT:
//    - Operands held constant.
//    - If cnt!=0: cnt decrements each edge.
//    - If cnt==0: the edge captures ZLO<=mul_zlow and ZHI<=mul_zhigh, then goes to LO.
//    - Capture therefore happens at edge k+SETTLE_CYCLES.
//  - LO: res_valid=1, res_data=zlo_q, res_last=0.
//    - On a handshake: go to HI.
//    - Otherwise hold; data must stay stable.
//  - HI: res_valid=1, res_data=zhi_q, res_last=1.
//    - On a handshake: go to IDLE.
//  - Minimum latency, start accepted to last handshake: SETTLE_CYCLES+2 edges with res_ready held at 1.
//  - start while busy=0 is the only accepted request; start during WAIT/LO/HI is ignored and not queued.
//    This includes the cycle in which the HI handshake completes.
//  - Back-to-back issue: the earliest next accept is the edge after returning to IDLE.
//  - Holding behaviour:
//    - Operand regs keep their last values after completion, so mul_in1/mul_in2 change only on an accept.
//    - ZHI/ZLO change only at capture.
//    - res_sign/res_ovf are combinational from ZHI/ZLO and valid from LO onward.
//  - Arithmetic: the block performs no arithmetic on the product; the 64 bits pass unmodified.
//  - res_ready while res_valid=0 has no effect.
// TESTING
//  Bench ties mul_in1/mul_in2 to a behavioural signed 64-bit multiplier that drives mul_zlow/mul_zhigh.
//  1. op_a=7, op_b=6, SETTLE_CYCLES=2, res_ready=1
//     -> capture 2 edges after accept; beats 0x0000002A (last=0) then 0x00000000 (last=1); ovf=0.
//  2. op_a=0xFFFFFFFD (-3), op_b=5
//     -> zlo_q=0xFFFFFFF1, zhi_q=0xFFFFFFFF, res_sign=1, res_ovf=0.
//  3. op_a=op_b=0x80000000
//     -> zlo_q=0x00000000, zhi_q=0x40000000, res_sign=0, res_ovf=1.
//  4. res_ready=0 for 5 cycles in LO, with start pulsed in the same window
//     -> res_valid held, res_data stable at ZLO, start ignored, busy=1.
//  5. clear asserted during WAIT
//     -> busy, res_valid and zlo_q/zhi_q go to 0 without waiting for an edge; no beat ever appears.
//  6. start held high across two operations (3*4 then -1*-1)
//     -> second accept one edge after the HI handshake; beats 12, 0, then 1, 0.

Source files
------------

// File: rtl/mul_issue_ctrl_if.sv
// Port bundle between the multiplier sequencing stage and its surroundings:
// operand request, combinational multiplier hookup and the two-beat result stream.
interface mul_issue_ctrl_if;
  logic               start;
  logic signed [31:0] op_a;
  logic signed [31:0] op_b;
  logic signed [31:0] mul_in1;
  logic signed [31:0] mul_in2;
  logic        [31:0] mul_zlow;
  logic        [31:0] mul_zhigh;
  logic               busy;
  logic               res_valid;
  logic               res_ready;
  logic        [31:0] res_data;
  logic               res_last;
  logic        [31:0] zlo_q;
  logic        [31:0] zhi_q;
  logic               res_sign;
  logic               res_ovf;

  modport master (
    input  start, op_a, op_b, mul_zlow, mul_zhigh, res_ready,
    output mul_in1, mul_in2, busy, res_valid, res_data, res_last,
           zlo_q, zhi_q, res_sign, res_ovf
  );

  modport slave (
    output start, op_a, op_b, mul_zlow, mul_zhigh, res_ready,
    input  mul_in1, mul_in2, busy, res_valid, res_data, res_last,
           zlo_q, zhi_q, res_sign, res_ovf
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Sequencer around a combinational 32x32 signed multiplier: latch operands, wait for
// the product to settle, capture it into ZHI/ZLO and return it as LO then HI beats.
module mul_issue_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input logic              clock,
  input logic              clear,
  mul_issue_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, LO, HI} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic signed [31:0] a_p0, b_p0;
  logic        [31:0] zlo_p1, zhi_p1;
  logic               accept, capture;
  logic               busy, res_valid, res_last;
  logic        [31:0] res_data;

  // A product that fits in 32 signed bits has ZHI equal to the sign extension of ZLO.
  function automatic logic exceeds_s32(input logic [31:0] hi, input logic [31:0] lo);
    return hi != {32{lo[31]}};
  endfunction

  assign accept  = (state == IDLE) && bus.start;
  assign capture = (state == WAIT) && (cnt == '0);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.start)     state_next = WAIT;
      WAIT: if (cnt == '0)     state_next = LO;
      LO:   if (bus.res_ready) state_next = HI;
      HI:   if (bus.res_ready) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b1;
    res_valid = 1'b0;
    res_last  = 1'b0;
    res_data  = '0;
    unique case (state)
      IDLE: busy = 1'b0;
      WAIT: ;
      LO: begin
        res_valid = 1'b1;
        res_data  = zlo_p1;
      end
      HI: begin
        res_valid = 1'b1;
        res_last  = 1'b1;
        res_data  = zhi_p1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Stage p0: operand latch and settle counter
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      a_p0 <= '0;
      b_p0 <= '0;
      cnt  <= '0;
    end else if (accept) begin
      a_p0 <= bus.op_a;
      b_p0 <= bus.op_b;
      cnt  <= CNT_LOAD;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Stage p1: product capture, held until the next capture
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      zlo_p1 <= '0;
      zhi_p1 <= '0;
    end else if (capture) begin
      zlo_p1 <= bus.mul_zlow;
      zhi_p1 <= bus.mul_zhigh;
    end
  end

  assign bus.mul_in1   = a_p0;
  assign bus.mul_in2   = b_p0;
  assign bus.busy      = busy;
  assign bus.res_valid = res_valid;
  assign bus.res_last  = res_last;
  assign bus.res_data  = res_data;
  assign bus.zlo_q     = zlo_p1;
  assign bus.zhi_q     = zhi_p1;
  assign bus.res_sign  = zhi_p1[31];
  assign bus.res_ovf   = exceeds_s32(zhi_p1, zlo_p1);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural signed multiplier on the
// mul_in/mul_z hookup; table of products plus hand-written handshake/reset sequences.
module tb_mul_issue_ctrl;

  logic clock;
  logic clear;
  int   total;
  int   bad;

  mul_issue_ctrl_if bus();

  mul_issue_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  logic signed [63:0] prod;
  assign prod = $signed({{32{bus.mul_in1[31]}}, bus.mul_in1}) *
                $signed({{32{bus.mul_in2[31]}}, bus.mul_in2});
  assign bus.mul_zlow  = prod[31:0];
  assign bus.mul_zhigh = prod[63:32];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required test end");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        sgn;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One posedge, then settle on the following negedge for sampling/driving.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Full operation with res_ready held high; caller is at a negedge in IDLE.
  task automatic run_vec(input vec_t v);
    bus.op_a      = v.a;
    bus.op_b      = v.b;
    bus.start     = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    check("accept_busy", 32'(bus.busy), 32'd1);
    check("accept_in1", bus.mul_in1, v.a);
    check("wait_valid", 32'(bus.res_valid), 32'd0);
    tick();
    check("wait2_valid", 32'(bus.res_valid), 32'd0);
    tick();
    check("lo_valid", 32'(bus.res_valid), 32'd1);
    check("lo_data", bus.res_data, v.lo);
    check("lo_last", 32'(bus.res_last), 32'd0);
    check("zlo_q", bus.zlo_q, v.lo);
    check("zhi_q", bus.zhi_q, v.hi);
    check("res_sign", 32'(bus.res_sign), 32'(v.sgn));
    check("res_ovf", 32'(bus.res_ovf), 32'(v.ovf));
    tick();
    check("hi_data", bus.res_data, v.hi);
    check("hi_last", 32'(bus.res_last), 32'd1);
    tick();
    check("done_busy", 32'(bus.busy), 32'd0);
    check("done_valid", 32'(bus.res_valid), 32'd0);
    check("done_data", bus.res_data, 32'd0);
    check("done_in1", bus.mul_in1, v.a);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{32'd7,        32'd6,        32'h0000002A, 32'h00000000, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 1'b1};
    vecs[3] = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h00000000, 1'b0, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
    vecs[5] = '{32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b0, 1'b1};

    clear         = 1'b1;
    bus.start     = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_data", bus.res_data, 32'd0);
    check("rst_in1", bus.mul_in1, 32'd0);
    check("rst_ovf", 32'(bus.res_ovf), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Back-pressure in LO with start pulses that must be ignored.
    bus.op_a      = 32'd7;
    bus.op_b      = 32'd6;
    bus.start     = 1'b1;
    bus.res_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      bus.op_a  = 32'd100 + 32'(i);
      check("stall_valid", 32'(bus.res_valid), 32'd1);
      check("stall_data", bus.res_data, 32'h0000002A);
      check("stall_busy", 32'(bus.busy), 32'd1);
      check("stall_last", 32'(bus.res_last), 32'd0);
      tick();
      check("stall_in1", bus.mul_in1, 32'd7);
    end
    bus.start     = 1'b0;
    bus.res_ready = 1'b1;
    check("stall_lo_final", bus.res_data, 32'h0000002A);
    tick();
    check("stall_hi", bus.res_data, 32'd0);
    check("stall_hi_last", 32'(bus.res_last), 32'd1);
    tick();
    check("stall_idle", 32'(bus.busy), 32'd0);
    check("stall_in1_kept", bus.mul_in1, 32'd7);

    // Asynchronous clear during WAIT.
    bus.op_a  = 32'd3;
    bus.op_b  = 32'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("pre_clr_zlo", bus.zlo_q, 32'h0000002A);
    #2;
    clear = 1'b1;
    #1;
    check("clr_busy", 32'(bus.busy), 32'd0);
    check("clr_valid", 32'(bus.res_valid), 32'd0);
    check("clr_zlo", bus.zlo_q, 32'd0);
    check("clr_zhi", bus.zhi_q, 32'd0);
    check("clr_in1", bus.mul_in1, 32'd0);
    @(negedge clock);
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_clr_valid", 32'(bus.res_valid), 32'd0);
      check("post_clr_busy", 32'(bus.busy), 32'd0);
    end

    // start held high across two operations.
    bus.op_a      = 32'd3;
    bus.op_b      = 32'd4;
    bus.start     = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.op_a = 32'hFFFFFFFF;
    bus.op_b = 32'hFFFFFFFF;
    check("b2b_in1_first", bus.mul_in1, 32'd3);
    tick();
    check("b2b_in1_held", bus.mul_in1, 32'd3);
    tick();
    check("b2b_lo1", bus.res_data, 32'd12);
    check("b2b_lo1_valid", 32'(bus.res_valid), 32'd1);
    tick();
    check("b2b_hi1", bus.res_data, 32'd0);
    check("b2b_hi1_last", 32'(bus.res_last), 32'd1);
    tick();
    check("b2b_idle_busy", 32'(bus.busy), 32'd0);
    check("b2b_idle_in1", bus.mul_in1, 32'd3);
    tick();
    bus.start = 1'b0;
    check("b2b_accept2_busy", 32'(bus.busy), 32'd1);
    check("b2b_accept2_in1", bus.mul_in1, 32'hFFFFFFFF);
    tick();
    check("b2b_wait2_valid", 32'(bus.res_valid), 32'd0);
    tick();
    check("b2b_lo2", bus.res_data, 32'd1);
    check("b2b_lo2_last", 32'(bus.res_last), 32'd0);
    tick();
    check("b2b_hi2", bus.res_data, 32'd0);
    check("b2b_hi2_last", 32'(bus.res_last), 32'd1);
    tick();
    check("b2b_end_busy", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
